logic_gates_2: RTL and testbench



---
 rtl/logic_gates_2.sv | 52 +++++
 tb/tb_logic_gates_2.sv | 134 +++++++++++++
 2 files changed

// File: rtl/logic_gates_2.sv
// Registered two-input gate bank: seven bitwise functions of iA/iB, one clock of latency.
// Every result register clears asynchronously, including the inverting outputs.
module logic_gates_2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oAnd,
  output logic [WIDTH-1:0] oOr,
  output logic [WIDTH-1:0] oNot,
  output logic [WIDTH-1:0] oNand,
  output logic [WIDTH-1:0] oNor,
  output logic [WIDTH-1:0] oXor,
  output logic [WIDTH-1:0] oXnor
);

  logic [WIDTH-1:0] and_d, or_d, not_d, nand_d, nor_d, xor_d, xnor_d;

  always_comb begin
    and_d  = iA & iB;
    or_d   = iA | iB;
    not_d  = ~iA;
    nand_d = ~(iA & iB);
    nor_d  = ~(iA | iB);
    xor_d  = iA ^ iB;
    xnor_d = ~(iA ^ iB);
  end

  // Reset value is zero for all outputs, not the gate function of the inputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oAnd  <= '0;
      oOr   <= '0;
      oNot  <= '0;
      oNand <= '0;
      oNor  <= '0;
      oXor  <= '0;
      oXnor <= '0;
    end else begin
      oAnd  <= and_d;
      oOr   <= or_d;
      oNot  <= not_d;
      oNand <= nand_d;
      oNor  <= nor_d;
      oXor  <= xor_d;
      oXnor <= xnor_d;
    end
  end

endmodule

// File: tb/tb_logic_gates_2.sv
// Scoreboard bench for logic_gates_2: 1-bit and 8-bit instances share clock and reset.
module tb_logic_gates_2;

  logic clk = 1'b0;
  logic rst_n;
  logic a1, b1;
  logic [7:0] a8, b8;
  logic and1, or1, not1, nand1, nor1, xor1, xnor1;
  logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [6:0]  e1;
    logic [55:0] e8;
  } exp_t;
  exp_t q[$];

  // Directed vectors: {a,b} and packed {and,or,not,nand,nor,xor,xnor}.
  logic [1:0]  p1[6];
  logic [15:0] p8[6];
  logic [6:0]  r1[6];
  logic [55:0] r8[6];

  always #5 clk = ~clk;

  logic_gates_2 #(.WIDTH(1)) u_dut1 (
    .iClk(clk), .iRst_n(rst_n), .iA(a1), .iB(b1),
    .oAnd(and1), .oOr(or1), .oNot(not1), .oNand(nand1),
    .oNor(nor1), .oXor(xor1), .oXnor(xnor1)
  );

  logic_gates_2 #(.WIDTH(8)) u_dut8 (
    .iClk(clk), .iRst_n(rst_n), .iA(a8), .iB(b8),
    .oAnd(and8), .oOr(or8), .oNot(not8), .oNand(nand8),
    .oNor(nor8), .oXor(xor8), .oXnor(xnor8)
  );

  wire [6:0]  out1 = {and1, or1, not1, nand1, nor1, xor1, xnor1};
  wire [55:0] out8 = {and8, or8, not8, nand8, nor8, xor8, xnor8};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input int i, input int n);
    repeat (n) begin
      @(negedge clk);
      {a1, b1} = p1[i];
      {a8, b8} = p8[i];
      q.push_back({r1[i], r8[i]});
    end
  endtask

  // Monitor: every rising edge out of reset presents one result.
  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("w1_result", {57'd0, out1}, {57'd0, e.e1});
      chk("w8_result", {8'd0, out8}, {8'd0, e.e8});
    end
  end

  initial begin
    p1[0] = 2'b00; p8[0] = 16'h0000; r1[0] = 7'b0011101; r8[0] = 56'h00_00_FF_FF_FF_00_FF;
    p1[1] = 2'b10; p8[1] = 16'hF0CC; r1[1] = 7'b0101010; r8[1] = 56'hC0_FC_0F_3F_03_3C_C3;
    p1[2] = 2'b01; p8[2] = 16'h1234; r1[2] = 7'b0111010; r8[2] = 56'h10_36_ED_EF_C9_26_D9;
    p1[3] = 2'b11; p8[3] = 16'hA55A; r1[3] = 7'b1100001; r8[3] = 56'h00_FF_5A_FF_00_FF_00;
    p1[4] = 2'b00; p8[4] = 16'h3C0F; r1[4] = 7'b0011101; r8[4] = 56'h0C_3F_C3_F3_C0_33_CC;
    p1[5] = 2'b11; p8[5] = 16'hFFFF; r1[5] = 7'b1100001; r8[5] = 56'hFF_FF_00_00_00_00_FF;

    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hF0; b8 = 8'hCC;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_async_w1", {57'd0, out1}, 64'd0);
    chk("reset_async_w8", {8'd0, out8}, 64'd0);
    repeat (2) @(negedge clk);
    chk("reset_hold_w1", {57'd0, out1}, 64'd0);
    chk("reset_hold_w8", {8'd0, out8}, 64'd0);

    // First edge after release loads (1,1) and (F0,CC).
    rst_n = 1'b1;
    q.push_back({7'b1100001, 56'hC0_FC_0F_3F_03_3C_C3});

    for (int i = 0; i < 5; i++) apply(i, 3);

    // Latency: A rises just after an edge with B=1; AND must wait for the next edge.
    apply(2, 1);
    @(posedge clk);
    #2;
    a1 = 1'b1;
    q.push_back({r1[3], r8[2]});
    #1;
    chk("latency_hold", {63'd0, and1}, 64'd0);
    @(posedge clk);

    for (int k = 0; k < 6; k++) apply(k, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midreset_async_w1", {57'd0, out1}, 64'd0);
    chk("midreset_async_w8", {8'd0, out8}, 64'd0);
    @(posedge clk);
    #2;
    chk("midreset_hold_w1", {57'd0, out1}, 64'd0);
    chk("midreset_hold_w8", {8'd0, out8}, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    {a1, b1} = p1[3];
    {a8, b8} = p8[3];
    q.push_back({r1[3], r8[3]});
    apply(1, 2);
    apply(4, 1);

    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
